// File: rtl/conv_seq_ctrl.sv
// Sequencing controller for the 64B/66B->8B/10B converter: screens sync headers,
// pulses the converter, schedules periodic error injection and reports per-block results.
module conv_seq_ctrl #(
  parameter int CONV_LAT = 1,
  parameter int PERIOD_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [65:0]         s_din_66b,
  input  logic                s_kin,
  input  logic                inj_arm,
  input  logic [PERIOD_W-1:0] inj_period,
  input  logic                clr_cnt,
  output logic                conv_en,
  output logic [65:0]         conv_din_66b,
  output logic                conv_kin,
  output logic                conv_err_inj,
  input  logic                conv_disp_err_original,
  input  logic                conv_disp_err_corrupted,
  input  logic                conv_kin_err_original,
  input  logic                conv_kin_err_corrupted,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_injected,
  output logic                m_detected,
  output logic                m_false_err,
  output logic [CNT_W-1:0]    cnt_blocks,
  output logic [CNT_W-1:0]    cnt_injected,
  output logic [CNT_W-1:0]    cnt_detected,
  output logic [CNT_W-1:0]    cnt_sync_err
);

  localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

  state_t              state;
  logic [LW-1:0]       wcnt;
  logic [PERIOD_W-1:0] ph;
  logic                inj_blk;

  logic accept;
  logic sync_ok;
  logic inj_now;
  logic sample;
  logic detected;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Sync headers 01/10 are data/control; 00/11 are illegal and get dropped
  assign accept   = s_valid & s_ready;
  assign sync_ok  = s_din_66b[65] ^ s_din_66b[64];
  assign inj_now  = inj_arm && (inj_period != '0) && (ph == (inj_period - PERIOD_W'(1)));
  assign sample   = (state == WAIT) && (wcnt == '0);
  assign detected = conv_disp_err_corrupted | conv_kin_err_corrupted;

  // Block sequencing FSM with registered handshake, converter and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wcnt         <= '0;
      ph           <= '0;
      inj_blk      <= 1'b0;
      s_ready      <= 1'b0;
      conv_en      <= 1'b0;
      conv_din_66b <= '0;
      conv_kin     <= 1'b0;
      conv_err_inj <= 1'b0;
      m_valid      <= 1'b0;
      m_injected   <= 1'b0;
      m_detected   <= 1'b0;
      m_false_err  <= 1'b0;
    end else begin
      if (!inj_arm || (inj_period == '0)) begin
        ph <= '0;
      end else if (accept && sync_ok) begin
        ph <= inj_now ? '0 : ph + PERIOD_W'(1);
      end

      case (state)
        IDLE: begin
          s_ready <= !(accept && sync_ok);
          if (accept && sync_ok) begin
            state        <= ISSUE;
            conv_en      <= 1'b1;
            conv_din_66b <= s_din_66b;
            conv_kin     <= s_kin;
            inj_blk      <= inj_now;
            conv_err_inj <= inj_now;
          end
        end
        ISSUE: begin
          conv_en <= 1'b0;
          wcnt    <= LW'(CONV_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (sample) begin
            state        <= REPORT;
            conv_err_inj <= 1'b0;
            m_valid      <= 1'b1;
            m_injected   <= inj_blk;
            m_detected   <= detected;
            m_false_err  <= conv_disp_err_original | conv_kin_err_original;
          end else begin
            wcnt <= wcnt - LW'(1);
          end
        end
        REPORT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics; clear takes priority over any same-edge increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_blocks   <= '0;
      cnt_injected <= '0;
      cnt_detected <= '0;
      cnt_sync_err <= '0;
    end else if (clr_cnt) begin
      cnt_blocks   <= '0;
      cnt_injected <= '0;
      cnt_detected <= '0;
      cnt_sync_err <= '0;
    end else begin
      cnt_blocks   <= sat_inc(cnt_blocks, sample);
      cnt_injected <= sat_inc(cnt_injected, sample && inj_blk);
      cnt_detected <= sat_inc(cnt_detected, sample && inj_blk && detected);
      cnt_sync_err <= sat_inc(cnt_sync_err, accept && !sync_ok);
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: expected results queued at issue time,
// popped and compared by an independent monitor on each result handshake.
module tb_conv_seq_ctrl;
  localparam int CONV_LAT = 1;
  localparam int PERIOD_W = 8;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_kin, inj_arm, clr_cnt;
  logic [65:0] s_din_66b, conv_din_66b;
  logic [PERIOD_W-1:0] inj_period;
  logic conv_en, conv_kin, conv_err_inj;
  logic dis_o, dis_c, kin_o, kin_c;
  logic m_valid, m_ready, m_injected, m_detected, m_false_err;
  logic [CNT_W-1:0] cnt_blocks, cnt_injected, cnt_detected, cnt_sync_err;
  logic model_en, fe_model;

  typedef struct packed {logic inj; logic det; logic fe;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int en_count = 0;
  int en0;

  always #5 clk = ~clk;

  // Converter model: corrupted-disparity flag follows injection, original flag is bench-controlled
  assign dis_c = conv_err_inj & model_en;
  assign kin_c = 1'b0;
  assign dis_o = fe_model;
  assign kin_o = 1'b0;

  conv_seq_ctrl #(.CONV_LAT(CONV_LAT), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_din_66b(s_din_66b),
    .s_kin(s_kin), .inj_arm(inj_arm), .inj_period(inj_period), .clr_cnt(clr_cnt),
    .conv_en(conv_en), .conv_din_66b(conv_din_66b), .conv_kin(conv_kin),
    .conv_err_inj(conv_err_inj), .conv_disp_err_original(dis_o),
    .conv_disp_err_corrupted(dis_c), .conv_kin_err_original(kin_o),
    .conv_kin_err_corrupted(kin_c), .m_valid(m_valid), .m_ready(m_ready),
    .m_injected(m_injected), .m_detected(m_detected), .m_false_err(m_false_err),
    .cnt_blocks(cnt_blocks), .cnt_injected(cnt_injected), .cnt_detected(cnt_detected),
    .cnt_sync_err(cnt_sync_err)
  );

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [1:0] sync, input logic [63:0] pl, input logic k);
    bit ok = 1'b0;
    s_valid = 1'b1; s_din_66b = {sync, pl}; s_kin = k;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    chk("send_timeout", ok, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_ready && !m_valid && q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  // Scoreboard monitor: every result handshake must match the oldest queued expectation
  always @(negedge clk) begin
    if (conv_en) en_count++;
    if (rst && m_valid && m_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got inj=%0b det=%0b fe=%0b expected none",
                 m_injected, m_detected, m_false_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("m_injected", m_injected, e.inj);
        chk("m_detected", m_detected, e.det);
        chk("m_false_err", m_false_err, e.fe);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_din_66b = '0; s_kin = 1'b0; inj_arm = 1'b0;
    inj_period = '0; clr_cnt = 1'b0; m_ready = 1'b1; model_en = 1'b1; fe_model = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_conv_en", conv_en, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_conv_din", conv_din_66b, 66'd0);
    chk("rst_cnt_blocks", cnt_blocks, 4'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_after_rst", s_ready, 1'b1);

    // Single block, no injection
    q.push_back('{1'b0, 1'b0, 1'b0});
    send(2'b01, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("c1_conv_en", conv_en, 1'b1);
    chk("c1_err_inj", conv_err_inj, 1'b0);
    chk("c1_conv_din", conv_din_66b, {2'b01, 64'h0123_4567_89AB_CDEF});
    chk("c1_conv_kin", conv_kin, 1'b1);
    @(posedge clk); #1;
    chk("c2_conv_en", conv_en, 1'b0);
    chk("c2_m_valid", m_valid, 1'b0);
    @(posedge clk); #1;
    chk("c3_m_valid", m_valid, 1'b1);
    chk("c3_cnt_blocks", cnt_blocks, 4'd1);
    wait_idle();

    // Period 3: blocks 3 and 6 injected and detected
    inj_arm = 1'b1; inj_period = 8'd3;
    for (int i = 1; i <= 6; i++) begin
      logic inj;
      inj = (i % 3 == 0);
      q.push_back('{inj, inj, 1'b0});
      send(2'b10, 64'(i), 1'b0);
    end
    wait_idle();
    chk("p3_cnt_injected", cnt_injected, 4'd2);
    chk("p3_cnt_detected", cnt_detected, 4'd2);
    chk("p3_cnt_blocks", cnt_blocks, 4'd7);

    // Sync errors interleaved with period-2 injection
    inj_period = 8'd2; en0 = en_count;
    q.push_back('{1'b0, 1'b0, 1'b0}); send(2'b01, 64'hA1, 1'b0);
    send(2'b00, 64'hBAD0, 1'b0);
    q.push_back('{1'b1, 1'b1, 1'b0}); send(2'b01, 64'hA2, 1'b0);
    send(2'b11, 64'hBAD1, 1'b0);
    q.push_back('{1'b0, 1'b0, 1'b0}); send(2'b10, 64'hA3, 1'b0);
    q.push_back('{1'b1, 1'b1, 1'b0}); send(2'b10, 64'hA4, 1'b0);
    wait_idle();
    chk("se_conv_en_pulses", 66'(en_count - en0), 66'd4);
    chk("se_cnt_sync_err", cnt_sync_err, 4'd2);
    chk("se_cnt_injected", cnt_injected, 4'd4);
    chk("se_cnt_blocks", cnt_blocks, 4'd11);

    // Backpressure with a false error reported by the converter
    inj_arm = 1'b0; fe_model = 1'b1; m_ready = 1'b0;
    q.push_back('{1'b0, 1'b0, 1'b1});
    send(2'b01, 64'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 10 && !m_valid; i++) begin @(posedge clk); #1; end
    fe_model = 1'b0;
    repeat (5) begin
      chk("bp_m_valid", m_valid, 1'b1);
      chk("bp_s_ready", s_ready, 1'b0);
      chk("bp_m_false_err", m_false_err, 1'b1);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_s_ready_after", s_ready, 1'b1);
    chk("bp_m_valid_after", m_valid, 1'b0);
    chk("bp_cnt_blocks", cnt_blocks, 4'd12);

    // Reset in WAIT discards the in-flight block
    send(2'b01, 64'h5555, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("mr_conv_en", conv_en, 1'b0);
    chk("mr_conv_din", conv_din_66b, 66'd0);
    chk("mr_conv_kin", conv_kin, 1'b0);
    chk("mr_s_ready", s_ready, 1'b0);
    chk("mr_cnt_blocks", cnt_blocks, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_s_ready_after", s_ready, 1'b1);
    repeat (5) begin
      chk("mr_no_m_valid", m_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Saturation: 17 blocks on a 4-bit counter, plus one drop
    for (int i = 0; i < 17; i++) begin
      q.push_back('{1'b0, 1'b0, 1'b0});
      send(2'b01, 64'(i), 1'b0);
    end
    send(2'b11, 64'h0, 1'b0);
    wait_idle();
    chk("sat_cnt_blocks", cnt_blocks, 4'd15);
    chk("sat_cnt_sync_err", cnt_sync_err, 4'd1);
    chk("sat_cnt_injected", cnt_injected, 4'd0);

    // Clear on the sample edge beats the injected-count increment
    inj_arm = 1'b1; inj_period = 8'd1;
    q.push_back('{1'b1, 1'b1, 1'b0});
    send(2'b10, 64'hC0FFEE, 1'b0);
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_m_valid", m_valid, 1'b1);
    chk("clr_cnt_blocks", cnt_blocks, 4'd0);
    chk("clr_cnt_injected", cnt_injected, 4'd0);
    chk("clr_cnt_detected", cnt_detected, 4'd0);
    chk("clr_cnt_sync_err", cnt_sync_err, 4'd0);
    wait_idle();
    chk("queue_drained", 66'(q.size()), 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
